// File: rtl/pipe_pkg.sv
// Shared control-bundle bit positions and constants for the pipeline stage registers.
package pipe_pkg;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int M_READ      = 0;
  localparam int M_WRITE     = 1;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic W-bit elastic register: main entry drives the outputs, one skid entry
// absorbs the bundle that arrives while the main entry is stalled.
module pipe_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         main_free;

  // skid_valid is a flop, so in_ready is registered as well
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  // Skid entry is always older than any incoming bundle, so it refills main first
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_exmem_stage.sv
// EX/MEM pipeline register with valid/ready flow control, flush and a
// forwarding port driven only from the bundle currently presented to MEM.
module pipe_exmem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int INSTR_W       = 32,
  parameter int WB_W          = 2,
  parameter int M_W           = 2,
  parameter bit ZERO_REG_HARD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [REG_W-1:0]   dest_reg_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [WB_W-1:0]    wb_ctrl_in,
  input  logic [M_W-1:0]     mem_ctrl_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  store_data_out,
  output logic [REG_W-1:0]   dest_reg_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [WB_W-1:0]    wb_ctrl_out,
  output logic [M_W-1:0]     mem_ctrl_out,
  output logic               fwd_valid,
  output logic [REG_W-1:0]   fwd_reg,
  output logic [DATA_W-1:0]  fwd_data
);

  localparam int BUNDLE_W = 2 * DATA_W + REG_W + INSTR_W + WB_W + M_W;

  logic [BUNDLE_W-1:0] bundle_in;
  logic [BUNDLE_W-1:0] bundle_out;
  logic                dest_is_zero;

  assign bundle_in = {alu_result_in, store_data_in, dest_reg_in,
                      instr_in, wb_ctrl_in, mem_ctrl_in};

  pipe_skid_reg #(
    .W(BUNDLE_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (bundle_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (bundle_out)
  );

  assign {alu_result_out, store_data_out, dest_reg_out,
          instr_out, wb_ctrl_out, mem_ctrl_out} = bundle_out;

  // The skid entry is younger and stalled, so it is never a forwarding source
  assign dest_is_zero = (dest_reg_out == '0);
  assign fwd_valid    = out_valid & wb_ctrl_out[WB_REGWRITE] & ~(ZERO_REG_HARD & dest_is_zero);
  assign fwd_reg      = dest_reg_out;
  assign fwd_data     = alu_result_out;

endmodule

// File: tb/tb_pipe_exmem_stage.sv
// Self-checking bench for pipe_exmem_stage: directed vector table, hand-written
// forwarding/reset sequences and a queue scoreboard watching every transfer.
module tb_pipe_exmem_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  dest_reg_in;
  logic [31:0] instr_in;
  logic [1:0]  wb_ctrl_in;
  logic [1:0]  mem_ctrl_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [4:0]  dest_reg_out;
  logic [31:0] instr_out;
  logic [1:0]  wb_ctrl_out;
  logic [1:0]  mem_ctrl_out;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  int checks;
  int errors;
  bit mon_en;

  logic [104:0] sb_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        rdy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic [31:0] ealu;
  } vec_t;

  vec_t vecs[17];

  pipe_exmem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .dest_reg_in   (dest_reg_in),
    .instr_in      (instr_in),
    .wb_ctrl_in    (wb_ctrl_in),
    .mem_ctrl_in   (mem_ctrl_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result_out(alu_result_out),
    .store_data_out(store_data_out),
    .dest_reg_out  (dest_reg_out),
    .instr_out     (instr_out),
    .wb_ctrl_out   (wb_ctrl_out),
    .mem_ctrl_out  (mem_ctrl_out),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] alu, input logic [4:0] dest,
                               input logic [1:0] wb, input logic rdy, input logic fl);
    in_valid      = iv;
    alu_result_in = alu;
    store_data_in = ~alu;
    dest_reg_in   = dest;
    instr_in      = alu ^ 32'hA5A5_0000;
    wb_ctrl_in    = wb;
    mem_ctrl_in   = alu[3:2];
    out_ready     = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  // Occupancy model: the stage holds exactly the bundles accepted but not yet
  // consumed or killed, so valid/ready follow from the queue depth.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("sb_out_valid", 128'(out_valid), 128'(sb_q.size() != 0));
      checkOutput("sb_in_ready", 128'(in_ready), 128'(sb_q.size() < 2));
      if (out_valid && out_ready && !reset) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_out", 128'(1), 128'(0));
        end else begin
          checkOutput("sb_payload",
                      128'({alu_result_out, store_data_out, dest_reg_out,
                            instr_out, wb_ctrl_out, mem_ctrl_out}),
                      128'(sb_q.pop_front()));
        end
      end
      if (reset || flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back({alu_result_in, store_data_in, dest_reg_in,
                        instr_in, wb_ctrl_in, mem_ctrl_in});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset  = 1'b1;

    //            iv    alu           rdy   fl    eov   eir   ealu
    vecs[0]  = '{1'b1, 32'h1234,    1'b1, 1'b0, 1'b1, 1'b1, 32'h1234};
    vecs[1]  = '{1'b1, 32'h1,       1'b1, 1'b0, 1'b1, 1'b1, 32'h1};
    vecs[2]  = '{1'b1, 32'h2,       1'b1, 1'b0, 1'b1, 1'b1, 32'h2};
    vecs[3]  = '{1'b1, 32'h3,       1'b1, 1'b0, 1'b1, 1'b1, 32'h3};
    vecs[4]  = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h10,      1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
    vecs[6]  = '{1'b1, 32'h11,      1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[7]  = '{1'b1, 32'h55,      1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[8]  = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b1, 32'h11};
    vecs[9]  = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h20,      1'b0, 1'b0, 1'b1, 1'b1, 32'h20};
    vecs[11] = '{1'b1, 32'h21,      1'b0, 1'b0, 1'b1, 1'b0, 32'h20};
    vecs[12] = '{1'b1, 32'h99,      1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 32'h30,      1'b1, 1'b0, 1'b1, 1'b1, 32'h30};
    vecs[15] = '{1'b1, 32'h31,      1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    applyStimulus(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_alu", 128'(alu_result_out), 128'(0));
    checkOutput("reset_fwd_valid", 128'(fwd_valid), 128'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].alu, vecs[i].alu[4:0], vecs[i].alu[1:0],
                    vecs[i].rdy, vecs[i].fl);
      checkOutput($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].eov));
      checkOutput($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].eir));
      if (vecs[i].eov)
        checkOutput($sformatf("vec%0d_alu", i), 128'(alu_result_out), 128'(vecs[i].ealu));
    end

    $display("[TB] forwarding sequence");
    applyStimulus(1'b1, 32'hABCD, 5'd0, 2'b01, 1'b0, 1'b0);
    checkOutput("fwd_zero_reg_valid", 128'(fwd_valid), 128'(0));
    applyStimulus(1'b1, 32'hABCD, 5'd7, 2'b01, 1'b1, 1'b0);
    checkOutput("fwd_r7_valid", 128'(fwd_valid), 128'(1));
    checkOutput("fwd_r7_reg", 128'(fwd_reg), 128'(7));
    checkOutput("fwd_r7_data", 128'(fwd_data), 128'(32'hABCD));
    applyStimulus(1'b1, 32'h5555, 5'd7, 2'b00, 1'b1, 1'b0);
    checkOutput("fwd_no_regwrite", 128'(fwd_valid), 128'(0));
    applyStimulus(1'b0, 32'h0, 5'd0, 2'b01, 1'b1, 1'b0);
    checkOutput("fwd_empty", 128'(fwd_valid), 128'(0));

    $display("[TB] reset with skid full");
    applyStimulus(1'b1, 32'h40, 5'd3, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h41, 5'd4, 2'b01, 1'b0, 1'b0);
    checkOutput("skid_full_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;
    applyStimulus(1'b1, 32'h42, 5'd5, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_mid_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_mid_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_mid_payload",
                128'({alu_result_out, store_data_out, dest_reg_out,
                      instr_out, wb_ctrl_out, mem_ctrl_out}), 128'(0));
    checkOutput("rst_mid_fwd_valid", 128'(fwd_valid), 128'(0));

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), r, r[8:4], r[10:9],
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("drain_empty", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_exmem_stage.md
Name: pipe_exmem_stage

Overview:
- Parametrised, elastic EX/MEM pipeline register; the next generation of the fixed 32-bit EX/MEM latch.
- Adds valid/ready flow control, a one-entry skid buffer for full throughput under backpressure, and flush.
- Exposes a forwarding port for the hazard unit.
- Sits between the ALU stage and the data-memory stage.

Parameters:
- DATA_W, 32: width of ALU result and store data.
- REG_W, 5: destination register index width.
- INSTR_W, 32: carried instruction word width.
- WB_W, 2: write-back control bundle width; bit WB_REGWRITE = register write enable.
- M_W, 2: memory control bundle width (read, write).
- ZERO_REG_HARD, 1: when 1, register index 0 is never reported as a forwarding source.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX stage presents a valid bundle.
- in_ready  out  1  stage can accept a bundle this cycle.
- alu_result_in  in  DATA_W  ALU result.
- store_data_in  in  DATA_W  second ALU operand (store data).
- dest_reg_in  in  REG_W  destination register.
- instr_in  in  INSTR_W  instruction word.
- wb_ctrl_in  in  WB_W  write-back controls.
- mem_ctrl_in  in  M_W  memory controls.
- flush  in  1  kill all held bundles (branch mispredict/exception).
- out_valid  out  1  MEM-side bundle valid.
- out_ready  in  1  MEM stage accepts the bundle.
- alu_result_out, store_data_out, dest_reg_out, instr_out, wb_ctrl_out, mem_ctrl_out  out  matching widths  registered bundle.
- fwd_valid  out  1  forwarding source valid.
- fwd_reg  out  REG_W  forwarding destination register.
- fwd_data  out  DATA_W  forwarding value.

Behaviour:
- Storage: main register (drives outputs) plus one skid entry, each with its own valid bit. Both are registered; no combinational in→out data path.
- in_ready is registered and equals !skid_valid. out_valid = main_valid.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: bundle accepted at edge N appears on outputs after edge N when the main register is free or draining. Throughput is 1 bundle/cycle while out_ready=1.
- Main update at the clock edge:
  - If main is empty or out_fire: main ← skid if skid_valid, else incoming if in_fire, else main_valid ← 0.
  - If main is full and out_ready=0 and in_fire: incoming goes to skid.
- Skid load: in_fire while main holds and is not draining. Skid drain: main takes the skid entry and the skid empties; a same-cycle in_fire is not possible because in_ready=0.
- Order is strictly FIFO; no bundle is duplicated or dropped except by flush.
- Flush (synchronous): main_valid and skid_valid ← 0 at the next edge. Flush beats a simultaneous in_fire (the incoming bundle is discarded) and a simultaneous out_fire (the MEM side consumed that bundle; this is legal). in_ready = 1 the cycle after flush.
- Payload registers are not cleared by flush; consumers must qualify with out_valid.
- Reset: all valid bits 0, in_ready 1, all payload outputs 0, fwd_valid 0. Reset mid-transfer discards all held bundles. Reset has priority over flush and over all transfers.
- Forwarding: fwd_valid = main_valid & wb_ctrl_out[WB_REGWRITE] & !(ZERO_REG_HARD & dest_reg_out==0). fwd_reg = dest_reg_out; fwd_data = alu_result_out. Combinational from the main register only; the skid entry is never forwarded (younger, stalled).
- Widths are passed through unmodified; no arithmetic.

Decomposition:
- Shared package pipe_pkg: WB_REGWRITE, WB_MEMTOREG, M_READ, M_WRITE bit positions; a NOP instruction constant.
- One natural sub-module, pipe_skid_reg: generic width-W valid/ready skid register with flush. pipe_exmem_stage packs the bundle into it and adds the forwarding logic.

Test Plan:
- Reset held 2 cycles, then in_valid=1, alu_result_in=0x1234 with out_ready=1 → one cycle later out_valid=1, alu_result_out=0x1234; in_ready stays 1.
- Stream 0x1,0x2,0x3 with out_ready=1 → outputs 0x1,0x2,0x3 on consecutive cycles, no bubbles.
- out_ready=0 while sending 0x10 then 0x11 → 0x10 held, in_ready drops to 0 after 0x11 enters skid; raise out_ready → 0x10 then 0x11 in order, in_ready returns to 1.
- Main and skid full, flush=1 together with in_valid=1 (0x99) → next cycle out_valid=0, in_ready=1; 0x99 never appears.
- Bundle with wb_ctrl REGWRITE=1, dest_reg=0 and ZERO_REG_HARD=1 → fwd_valid=0; same bundle with dest_reg=7 → fwd_valid=1, fwd_reg=7, fwd_data equals alu_result_out.
- reset asserted while skid is full → next cycle out_valid=0, in_ready=1, all payload outputs 0.
